// File: rtl/yutorina_bus_if_pkg.sv
// Shared definitions for the yutorina memory-access front end: FSM state codes,
// read/write encoding and the slave index that selects the scratch-pad memory.
package yutorina_bus_if_pkg;

  localparam int          IDX_W   = 3;
  localparam logic [IDX_W-1:0] SPM_IDX = 3'h1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_ACCESS = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STALL  = 3'd4
  } bus_if_state_e;

  // Slave index field sits in the top IDX_W bits of the word address.
  function automatic logic [IDX_W-1:0] slave_idx(input logic [29:0] a);
    return a[29 -: IDX_W];
  endfunction

endpackage

// File: rtl/yutorina_bus_if.sv
// Per-stage memory front end: SPM hits complete combinationally, everything else
// goes out on the shared bus through a req/grant/strobe/ready handshake.
module yutorina_bus_if
  import yutorina_bus_if_pkg::*;
#(
  parameter int WORD_DATA_W = 32,
  parameter int WORD_ADDR_W = 30,
  parameter int SPM_ADDR_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   as_,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] w_data,
  output logic [WORD_DATA_W-1:0] r_data,
  output logic                   busy,
  input  logic [WORD_DATA_W-1:0] spm_r_data,
  output logic [SPM_ADDR_W-1:0]  spm_addr,
  output logic                   spm_as_,
  output logic                   spm_rw,
  output logic [WORD_DATA_W-1:0] spm_w_data,
  input  logic [WORD_DATA_W-1:0] bus_r_data,
  input  logic                   bus_rdy_,
  input  logic                   bus_grnt_,
  output logic                   bus_req_,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_DATA_W-1:0] bus_w_data
);

  bus_if_state_e           r_state;
  bus_if_state_e           w_next;
  logic                    r_bus_req_;
  logic                    r_bus_as_;
  logic                    r_bus_rw;
  logic [WORD_ADDR_W-1:0]  r_bus_addr;
  logic [WORD_DATA_W-1:0]  r_bus_w_data;
  logic [WORD_DATA_W-1:0]  r_rd_buf;
  logic                    w_valid;
  logic                    w_spm_hit;

  assign w_valid   = !as_ && !flush;
  assign w_spm_hit = (slave_idx(addr) == SPM_IDX);

  assign spm_addr   = addr[SPM_ADDR_W-1:0];
  assign spm_rw     = rw;
  assign spm_w_data = w_data;

  assign bus_req_   = r_bus_req_;
  assign bus_as_    = r_bus_as_;
  assign bus_rw     = r_bus_rw;
  assign bus_addr   = r_bus_addr;
  assign bus_w_data = r_bus_w_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_bus_req_   <= 1'b1;
      r_bus_as_    <= 1'b1;
      r_bus_rw     <= READ;
      r_bus_addr   <= '0;
      r_bus_w_data <= '0;
      r_rd_buf     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_next == ST_REQ) begin
            r_bus_req_   <= 1'b0;
            r_bus_addr   <= addr;
            r_bus_rw     <= rw;
            r_bus_w_data <= w_data;
          end
        end
        ST_REQ: begin
          if (!bus_grnt_) r_bus_as_ <= 1'b0;
        end
        ST_ACCESS: r_bus_as_ <= 1'b1;
        ST_WAIT: begin
          if (!bus_rdy_) begin
            r_bus_req_ <= 1'b1;
            if (r_bus_rw == READ) r_rd_buf <= bus_r_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    r_data  = '0;
    busy    = 1'b0;
    spm_as_ = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) begin
          if (w_spm_hit) begin
            spm_as_ = 1'b0;
            r_data  = spm_r_data;
          end else begin
            busy   = 1'b1;
            w_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        busy = 1'b1;
        if (!bus_grnt_) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        busy   = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus_rdy_) begin
          r_data = (r_bus_rw == READ) ? bus_r_data : '0;
          w_next = stall ? ST_STALL : ST_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      ST_STALL: begin
        r_data = r_rd_buf;
        if (!stall) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset must quiet the stage-facing outputs even if the inputs request an SPM access.
    if (!rst) begin
      busy    = 1'b0;
      spm_as_ = 1'b1;
      r_data  = '0;
    end
  end

endmodule

// File: tb/tb_yutorina_bus_if.sv
// Bench for yutorina_bus_if: transaction-timeline reference model checked every
// negedge, plus directed sequences with hand-computed expectations.
module tb_yutorina_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, as_ = 1'b1, rw = 1'b1;
  logic [29:0] addr = '0;
  logic [31:0] w_data = '0, spm_r_data = '0, bus_r_data = '0;
  logic        bus_rdy_ = 1'b1, bus_grnt_ = 1'b1;
  logic [31:0] r_data, spm_w_data, bus_w_data;
  logic        busy, spm_as_, spm_rw, bus_req_, bus_as_, bus_rw;
  logic [11:0] spm_addr;
  logic [29:0] bus_addr;

  int n_checks = 0;
  int n_errors = 0;

  yutorina_bus_if dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .addr(addr), .as_(as_),
    .rw(rw), .w_data(w_data), .r_data(r_data), .busy(busy),
    .spm_r_data(spm_r_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
    .spm_rw(spm_rw), .spm_w_data(spm_w_data), .bus_r_data(bus_r_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_w_data(bus_w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is described by whether it has been granted and
  // how many cycles have passed since the grant cycle.
  bit          m_txn = 0, m_gnt = 0, m_hold = 0;
  int          m_since = 0;
  logic        m_rw = 1'b1;
  logic [29:0] m_addr = '0;
  logic [31:0] m_wd = '0, m_buf = '0;

  function automatic bit is_spm(input logic [29:0] a);
    return a[29:27] == 3'd1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_txn = 0; m_gnt = 0; m_hold = 0; m_since = 0; m_buf = '0;
    end else if (m_txn) begin
      if (!m_gnt) begin
        if (!bus_grnt_) begin m_gnt = 1; m_since = 1; end
      end else if (m_since == 1) begin
        m_since = 2;
      end else if (!bus_rdy_) begin
        m_txn = 0;
        if (m_rw) m_buf = bus_r_data;
        m_hold = stall;
      end
    end else if (m_hold) begin
      if (!stall) m_hold = 0;
    end else if (!as_ && !flush && !is_spm(addr)) begin
      m_txn = 1; m_gnt = 0; m_since = 0;
      m_addr = addr; m_rw = rw; m_wd = w_data;
    end
  end

  always @(negedge clk) begin
    logic        e_busy, e_spm_as_, e_req_, e_as_;
    logic [31:0] e_rd;
    e_busy = 0; e_spm_as_ = 1; e_req_ = 1; e_as_ = 1; e_rd = '0;
    if (!rst) begin
      e_busy = 0;
    end else if (m_txn) begin
      e_req_ = 0;
      if (!m_gnt) e_busy = 1;
      else if (m_since == 1) begin e_busy = 1; e_as_ = 0; end
      else if (bus_rdy_) e_busy = 1;
      else e_rd = m_rw ? bus_r_data : 32'h0;
    end else if (m_hold) begin
      e_rd = m_buf;
    end else if (!as_ && !flush) begin
      if (is_spm(addr)) begin e_spm_as_ = 0; e_rd = spm_r_data; end
      else e_busy = 1;
    end
    chk("m_busy", {31'b0, busy}, {31'b0, e_busy});
    chk("m_spm_as_", {31'b0, spm_as_}, {31'b0, e_spm_as_});
    chk("m_bus_req_", {31'b0, bus_req_}, {31'b0, e_req_});
    chk("m_bus_as_", {31'b0, bus_as_}, {31'b0, e_as_});
    chk("m_spm_addr", {20'b0, spm_addr}, {20'b0, addr[11:0]});
    if (!e_busy) chk("m_r_data", r_data, e_rd);
    if (!e_spm_as_) begin
      chk("m_spm_rw", {31'b0, spm_rw}, {31'b0, rw});
      chk("m_spm_w_data", spm_w_data, w_data);
    end
    if (rst && m_txn) begin
      chk("m_bus_addr", {2'b0, bus_addr}, {2'b0, m_addr});
      chk("m_bus_rw", {31'b0, bus_rw}, {31'b0, m_rw});
      if (!m_rw) chk("m_bus_w_data", bus_w_data, m_wd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    as_ = 1'b1; flush = 1'b0; stall = 1'b0; rw = 1'b1;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
  endtask

  int busy_cnt, as_cnt;

  initial begin
    // Reset state
    idle_in();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_bus_req_", {31'b0, bus_req_}, 32'd1);
    chk("rst_bus_as_", {31'b0, bus_as_}, 32'd1);
    chk("rst_bus_rw", {31'b0, bus_rw}, 32'd1);
    chk("rst_bus_addr", {2'b0, bus_addr}, 32'd0);
    chk("rst_bus_w_data", bus_w_data, 32'd0);
    chk("rst_r_data", r_data, 32'd0);

    // SPM read, index field 1
    step();
    addr = 30'h0800_0004; as_ = 1'b0; rw = 1'b1; spm_r_data = 32'hCAFE_0001;
    #3;
    chk("spm_r_data", r_data, 32'hCAFE_0001);
    chk("spm_busy", {31'b0, busy}, 32'd0);
    chk("spm_as_", {31'b0, spm_as_}, 32'd0);
    chk("spm_addr", {20'b0, spm_addr}, 32'h004);
    step();
    idle_in();
    #3;
    chk("spm_bus_req_", {31'b0, bus_req_}, 32'd1);

    // Bus read: grant in cycle 2, ready in cycle 6
    busy_cnt = 0; as_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      as_ = (k == 0) ? 1'b0 : 1'b1;
      addr = 30'h0000_0010; rw = 1'b1;
      bus_grnt_ = (k >= 2) ? 1'b0 : 1'b1;
      bus_rdy_ = (k >= 6) ? 1'b0 : 1'b1;
      bus_r_data = 32'hB0B0_0000 + 32'(k);
      #3;
      if (busy) busy_cnt++;
      if (!bus_as_) as_cnt++;
      if (k == 6) chk("bus_rd_data", r_data, 32'hB0B0_0006);
    end
    chk("bus_rd_busy_cycles", busy_cnt, 32'd6);
    chk("bus_rd_as_cycles", as_cnt, 32'd1);
    step(); idle_in();

    // Bus read completing under stall, held in STALL
    for (int k = 0; k < 8; k++) begin
      step();
      as_ = (k == 0 || k == 5) ? 1'b0 : 1'b1;
      addr = (k == 5) ? 30'h0800_0100 : 30'h0000_0020;
      rw = 1'b1;
      bus_grnt_ = (k >= 1) ? 1'b0 : 1'b1;
      bus_rdy_ = (k == 3) ? 1'b0 : 1'b1;
      bus_r_data = (k == 3) ? 32'h5A5A_1234 : 32'hDEAD_0000 + 32'(k);
      stall = (k >= 3 && k <= 5);
      #3;
      if (k >= 3 && k <= 6) begin
        chk("stall_r_data", r_data, 32'h5A5A_1234);
        chk("stall_busy", {31'b0, busy}, 32'd0);
      end
      if (k == 5) chk("stall_no_spm", {31'b0, spm_as_}, 32'd1);
      if (k == 7) chk("stall_exit_r_data", r_data, 32'd0);
    end
    idle_in();

    // Bus write
    for (int k = 0; k < 4; k++) begin
      step();
      as_ = (k == 0) ? 1'b0 : 1'b1;
      addr = 30'h0000_0030; rw = 1'b0; w_data = 32'h1234_5678;
      bus_grnt_ = (k >= 1) ? 1'b0 : 1'b1;
      bus_rdy_ = (k == 3) ? 1'b0 : 1'b1;
      bus_r_data = 32'hFFFF_0000;
      #3;
      if (k == 2) begin
        chk("wr_bus_rw", {31'b0, bus_rw}, 32'd0);
        chk("wr_bus_w_data", bus_w_data, 32'h1234_5678);
        chk("wr_bus_as_", {31'b0, bus_as_}, 32'd0);
      end
      if (k == 3) chk("wr_r_data", r_data, 32'd0);
    end
    step(); idle_in();

    // Flush blocks a new start, but not a transaction already in flight
    step();
    as_ = 1'b0; flush = 1'b1; addr = 30'h0000_0040; rw = 1'b1;
    #3;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    step(); idle_in();
    #3;
    chk("flush_no_req", {31'b0, bus_req_}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      as_ = (k == 0) ? 1'b0 : 1'b1;
      flush = (k >= 3);
      addr = 30'h0000_0044; rw = 1'b1;
      bus_grnt_ = (k >= 1) ? 1'b0 : 1'b1;
      bus_rdy_ = (k == 4) ? 1'b0 : 1'b1;
      bus_r_data = 32'h0F0F_0044;
      #3;
      if (k == 3) chk("flush_wait_busy", {31'b0, busy}, 32'd1);
      if (k == 4) chk("flush_done_r_data", r_data, 32'h0F0F_0044);
    end
    step(); idle_in();

    // Asynchronous reset during WAIT
    for (int k = 0; k < 4; k++) begin
      step();
      as_ = (k == 0) ? 1'b0 : 1'b1;
      addr = 30'h0000_0050; rw = 1'b1;
      bus_grnt_ = (k >= 1) ? 1'b0 : 1'b1;
      bus_rdy_ = 1'b1;
    end
    #1 rst = 1'b0;
    #1;
    chk("arst_bus_req_", {31'b0, bus_req_}, 32'd1);
    chk("arst_bus_as_", {31'b0, bus_as_}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    step(); idle_in();
    rst = 1'b1;
    step();
    as_ = 1'b0; addr = 30'h0000_0060; rw = 1'b1;
    #3;
    chk("arst_restart_busy", {31'b0, busy}, 32'd1);
    step();
    as_ = 1'b1; bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
    #3;
    chk("arst_restart_req_", {31'b0, bus_req_}, 32'd0);
    repeat (3) step();
    idle_in();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step();
      as_ = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      flush = ($urandom_range(0, 99) < 15);
      rw = $urandom_range(0, 1);
      addr = {3'($urandom_range(0, 3)), 27'($urandom)};
      w_data = $urandom;
      spm_r_data = $urandom;
      bus_r_data = $urandom;
      bus_grnt_ = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      bus_rdy_ = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        step();
        rst = 1'b1;
      end
    end
    step(); idle_in();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
